// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers:
// control-bundle layout, NOP control word and occupancy states.
package pipe_pkg;

    localparam int MEMREAD_B    = 0;
    localparam int MEMWRITE_B   = 1;
    localparam int MEMTOREG_LO  = 2;
    localparam int MEMTOREG_W   = 2;
    localparam int REGWRITE_B   = 4;
    localparam int REGDST_LO    = 5;
    localparam int REGDST_W     = 2;

    localparam int CTRL_W_EXMEM = 7;

    localparam logic [CTRL_W_EXMEM-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid bit plus data and control bundles,
// with load, valid-clear and flush (optionally clearing the payload).
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CTRL_W         = CTRL_W_EXMEM,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Slot storage; flush wins over load, load wins over clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            if (FLUSH_CLR_DATA != 0) begin
                r_data <= '0;
                r_ctrl <= '0;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with stall, flush and optional
// skid entry; empty slots always present a NOP control bundle.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CTRL_W         = CTRL_W_EXMEM,
    parameter int SKID           = 1,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    occ_e              r_state;
    occ_e              w_state_nxt;
    logic              w_drain;
    logic              w_acc;
    logic              w_main_ld;
    logic              w_main_clr;
    logic              w_skid_ld;
    logic              w_skid_clr;
    logic              w_main_v;
    logic              w_skid_v;
    logic [DATA_W-1:0] w_main_d;
    logic [CTRL_W-1:0] w_main_c;
    logic [DATA_W-1:0] w_skid_d;
    logic [CTRL_W-1:0] w_skid_c;
    logic [DATA_W-1:0] w_main_src_d;
    logic [CTRL_W-1:0] w_main_src_c;

    // With a skid entry, readiness depends only on held state
    assign in_ready = rst & ~stall &
        ((SKID != 0) ? ~w_skid_v : (~w_main_v | out_ready));

    assign w_drain = w_main_v & out_ready & ~stall;
    assign w_acc   = in_valid & in_ready & ~flush;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next-state: flush empties the stage unconditionally
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) w_state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (w_acc && !w_drain) w_state_nxt = ST_FULL;
                    else if (!w_acc && w_drain) w_state_nxt = ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_drain) w_state_nxt = ST_ONE;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: main is the older entry, skid the younger
    always_comb begin
        w_main_ld    = 1'b0;
        w_main_clr   = 1'b0;
        w_skid_ld    = 1'b0;
        w_skid_clr   = 1'b0;
        w_main_src_d = in_data;
        w_main_src_c = in_ctrl;
        if (!flush) begin
            unique case (r_state)
                ST_EMPTY: begin
                    w_main_ld = w_acc;
                end
                ST_ONE: begin
                    w_main_ld  = w_acc & w_drain;
                    w_main_clr = ~w_acc & w_drain;
                    w_skid_ld  = w_acc & ~w_drain;
                end
                ST_FULL: begin
                    w_main_ld    = w_drain;
                    w_skid_clr   = w_drain;
                    w_main_src_d = w_skid_d;
                    w_main_src_c = w_skid_c;
                end
                default: begin
                    w_main_ld = 1'b0;
                end
            endcase
        end
    end

    pipe_entry #(
        .DATA_W         (DATA_W),
        .CTRL_W         (CTRL_W),
        .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_ld),
        .i_clr   (w_main_clr),
        .i_flush (flush),
        .i_data  (w_main_src_d),
        .i_ctrl  (w_main_src_c),
        .o_valid (w_main_v),
        .o_data  (w_main_d),
        .o_ctrl  (w_main_c)
    );

    pipe_entry #(
        .DATA_W         (DATA_W),
        .CTRL_W         (CTRL_W),
        .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_ld),
        .i_clr   (w_skid_clr),
        .i_flush (flush),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_v),
        .o_data  (w_skid_d),
        .o_ctrl  (w_skid_c)
    );

    assign out_valid = w_main_v;
    assign out_data  = w_main_d;
    assign out_ctrl  = w_main_v ? w_main_c : CTRL_W'(CTRL_NOP);
    assign count     = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 is SKID=0 with data clear on
// flush, instance 1 is SKID=1 with stale data kept on flush.
module tb_pipe_stage_reg;

    typedef struct {
        logic [31:0] d;
        logic [6:0]  c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ir   [2];
    logic        st   [2];
    logic        fl   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] id   [2];
    logic [31:0] od   [2];
    logic [6:0]  ic   [2];
    logic [6:0]  oc   [2];
    logic [1:0]  cnt  [2];

    ent_t        m    [2][2];
    int          mc   [2];
    logic [31:0] held [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(7), .SKID(0), .FLUSH_CLR_DATA(1)
    ) u0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .in_ctrl(ic[0]),
        .stall(st[0]), .flush(fl[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .out_ctrl(oc[0]),
        .count(cnt[0])
    );

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(7), .SKID(1), .FLUSH_CLR_DATA(0)
    ) u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .in_ctrl(ic[1]),
        .stall(st[1]), .flush(fl[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .out_ctrl(oc[1]),
        .count(cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k]   = 0;
            held[k] = '0;
        end
    endtask

    // Compare against the FIFO model, then advance it by one cycle
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic er;
            logic dr;
            logic ac;
            logic ev;
            ev = (mc[k] > 0);
            if (k == 1) er = rst && !st[k] && (mc[k] < 2);
            else        er = rst && !st[k] && (mc[k] == 0 || ordy[k]);
            chk($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(er));
            chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(ev));
            chk($sformatf("out_data%0d", k), od[k],
                ev ? m[k][0].d : held[k]);
            chk($sformatf("out_ctrl%0d", k), 32'(oc[k]),
                ev ? 32'(m[k][0].c) : 32'h0);
            chk($sformatf("count%0d", k), 32'(cnt[k]), 32'(mc[k]));
            dr = ev && ordy[k] && !st[k];
            ac = iv[k] && er && !fl[k];
            if (fl[k]) begin
                if (k == 0) held[k] = '0;
                else if (ev) held[k] = m[k][0].d;
                mc[k] = 0;
            end else begin
                if (dr) begin
                    held[k] = m[k][0].d;
                    m[k][0] = m[k][1];
                    mc[k]--;
                end
                if (ac) begin
                    m[k][mc[k]].d = id[k];
                    m[k][mc[k]].c = ic[k];
                    mc[k]++;
                end
                if (mc[k] > 0) held[k] = m[k][0].d;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'b0;
            id[k]   = '0;
            ic[k]   = '0;
            ordy[k] = 1'b1;
            st[k]   = 1'b0;
            fl[k]   = 1'b0;
        end
    endtask

    task automatic drive(input int k, input logic v,
                         input logic [31:0] d, input logic [6:0] c,
                         input logic r, input logic s, input logic f);
        iv[k]   = v;
        id[k]   = d;
        ic[k]   = c;
        ordy[k] = r;
        st[k]   = s;
        fl[k]   = f;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'h0);
            chk($sformatf("rst_data%0d", k), od[k], 32'h0);
            chk($sformatf("rst_ctrl%0d", k), 32'(oc[k]), 32'h0);
            chk($sformatf("rst_count%0d", k), 32'(cnt[k]), 32'h0);
            chk($sformatf("rst_ready%0d", k), 32'(ir[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Release and stream
        drive(1, 1'b1, 32'h11, 7'h00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rel_valid", 32'(ov[1]), 32'h1);
        chk("rel_data", od[1], 32'h11);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'b1, 32'h12 + 32'(i), 7'h00, 1'b1, 1'b0, 1'b0);
            tick();
            chk("stream_count", 32'(cnt[1]), 32'h1);
            chk("stream_data", od[1], 32'h12 + 32'(i));
        end
        idle();
        tick();

        // Back-pressure into the skid entry
        drive(1, 1'b1, 32'hA1, 7'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hA2, 7'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_count", 32'(cnt[1]), 32'h2);
        chk("bp_ready", 32'(ir[1]), 32'h0);
        chk("bp_head", od[1], 32'hA1);
        idle();
        tick();
        chk("bp_second", od[1], 32'hA2);
        chk("bp_ready_back", 32'(ir[1]), 32'h1);
        tick();
        chk("bp_empty", 32'(cnt[1]), 32'h0);

        // Stall holds the entry and blocks input
        drive(1, 1'b1, 32'h55, 7'h10, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'h66, 7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", od[1], 32'h55);
            chk("stall_ctrl", 32'(oc[1]), 32'h10);
            chk("stall_ready", 32'(ir[1]), 32'h0);
            chk("stall_count", 32'(cnt[1]), 32'h1);
        end
        drive(1, 1'b1, 32'h66, 7'h00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("unstall_data", od[1], 32'h66);
        idle();
        tick();

        // Flush together with stall from FULL
        drive(1, 1'b1, 32'hB1, 7'h13, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hB2, 7'h14, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fl_full", 32'(cnt[1]), 32'h2);
        drive(1, 1'b1, 32'h77, 7'h7F, 1'b1, 1'b1, 1'b1);
        tick();
        chk("fl_valid", 32'(ov[1]), 32'h0);
        chk("fl_ctrl", 32'(oc[1]), 32'h0);
        chk("fl_count", 32'(cnt[1]), 32'h0);
        idle();
        tick();
        chk("fl_nostore", 32'(ov[1]), 32'h0);

        // Bubble control on the single-register instance
        drive(0, 1'b1, 32'h99, 7'h12, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bub_ctrl_live", 32'(oc[0]), 32'h12);
        idle();
        tick();
        chk("bub_ctrl_nop", 32'(oc[0]), 32'h0);
        chk("bub_valid", 32'(ov[0]), 32'h0);

        // Asynchronous reset between clock edges
        drive(1, 1'b1, 32'hC1, 7'h01, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hC2, 7'h02, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_full", 32'(cnt[1]), 32'h2);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(ov[1]), 32'h0);
        chk("ar_data", od[1], 32'h0);
        chk("ar_ctrl", 32'(oc[1]), 32'h0);
        chk("ar_count", 32'(cnt[1]), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic on both instances
        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom % 4) != 0;
                id[k]   = $urandom;
                ic[k]   = 7'($urandom);
                ordy[k] = ($urandom % 3) != 0;
                st[k]   = ($urandom % 8) == 0;
                fl[k]   = ($urandom % 16) == 0;
            end
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
